// File: rtl/reg_bank_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reg_bank_scoreboard                                          |
// | Description : MIPS 32-entry general-purpose register bank with two         |
// |               combinational read ports, one write-back port and a          |
// |               per-register pending-write scoreboard with a registered      |
// |               count of pending destinations. Register 0 reads as zero.     |
// |               Optional same-cycle write-to-read forwarding is enabled by   |
// |               defining REG_BANK_BYPASS_EN.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module reg_bank_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int SP_IDX   = 29,
  parameter int SP_RESET = 227
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic [4:0]        issue_addr,
  input  logic [4:0]        rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [4:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic [5:0]        pend_cnt
);

  logic [DATA_W-1:0] r_regs [32];
  logic [31:0]       r_pend;
  logic [5:0]        r_pend_cnt;
  logic [31:0]       w_pend_nxt;
  logic [5:0]        w_pend_cnt_nxt;
  logic              w_wr_ok;
  logic              w_issue_ok;

  // Writes and issues to register 0 are discarded.
  assign w_wr_ok    = wr_en && (wr_addr != 5'd0);
  assign w_issue_ok = issue_en && (issue_addr != 5'd0);

  // Next pending vector: write-back clears, issue sets; issue is applied last
  // so it wins when both target the same register on one edge.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wr_ok) begin
      w_pend_nxt[wr_addr] = 1'b0;
    end
    if (w_issue_ok) begin
      w_pend_nxt[issue_addr] = 1'b1;
    end
  end

  // Population count of the next pending vector, so the registered count
  // always tracks the registered vector exactly.
  always_comb begin
    w_pend_cnt_nxt = 6'd0;
    for (int i = 0; i < 32; i++) begin
      w_pend_cnt_nxt = w_pend_cnt_nxt + {5'd0, w_pend_nxt[i]};
    end
  end

  // Register file storage; register 0 is only ever loaded by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= (i == SP_IDX) ? DATA_W'(SP_RESET) : '0;
      end
    end else if (w_wr_ok) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  // Scoreboard vector and its count update together on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend     <= 32'd0;
      r_pend_cnt <= 6'd0;
    end else begin
      r_pend     <= w_pend_nxt;
      r_pend_cnt <= w_pend_cnt_nxt;
    end
  end

  assign pend_cnt = r_pend_cnt;

`ifdef REG_BANK_BYPASS_EN
  logic w_fwd_a;
  logic w_fwd_b;

  assign w_fwd_a = w_wr_ok && (rd_addr_a == wr_addr);
  assign w_fwd_b = w_wr_ok && (rd_addr_b == wr_addr);

  // Read ports forward the in-flight write-back data; a forwarded operand is
  // no longer waiting, so its busy flag is suppressed.
  always_comb begin
    rd_data_a = w_fwd_a ? wr_data : r_regs[rd_addr_a];
    rd_data_b = w_fwd_b ? wr_data : r_regs[rd_addr_b];
    busy_a    = r_pend[rd_addr_a] && !w_fwd_a;
    busy_b    = r_pend[rd_addr_b] && !w_fwd_b;
  end
`else
  // Read ports return stored contents; busy follows the pending bit.
  always_comb begin
    rd_data_a = r_regs[rd_addr_a];
    rd_data_b = r_regs[rd_addr_b];
    busy_a    = r_pend[rd_addr_a];
    busy_b    = r_pend[rd_addr_b];
  end
`endif

endmodule
`default_nettype wire

// File: doc/reg_bank_scoreboard.md
Name: reg_bank_scoreboard

Overview:
- MIPS general-purpose register bank.
- Its write port consumes the 5-bit destination address produced by the RegDst selection stage.
- Two asynchronous read ports plus a per-register pending-write scoreboard, so the multicycle control can detect a read of a destination still awaiting write-back.
- Sits between the RegDst/MemtoReg selection logic (write side) and the A/B operand registers (read side).

Parameters:
- DATA_W, 32, register width in bits.
- SP_IDX, 29, index of the stack-pointer register.
- SP_RESET, 227, reset value of register SP_IDX.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr_en  input  1  write-back strobe.
- wr_addr  input  5  write-back destination (RegDst output).
- wr_data  input  DATA_W  write-back data.
- issue_en  input  1  mark a destination as pending.
- issue_addr  input  5  destination being issued.
- rd_addr_a  input  5  read port A address.
- rd_data_a  output  DATA_W  read port A data.
- rd_addr_b  input  5  read port B address.
- rd_data_b  output  DATA_W  read port B data.
- busy_a  output  1  rd_addr_a has a pending write.
- busy_b  output  1  rd_addr_b has a pending write.
- pend_cnt  output  6  number of pending registers, 0..31.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately, including mid-operation):
  - All registers cleared to 0, except register SP_IDX, which loads SP_RESET.
  - All 32 pending bits cleared; pend_cnt=0.
  - Resulting outputs: rd_data reflects the reset contents, busy_a=busy_b=0.
- Register 0: hardwired to 0.
  - Writes to it are ignored.
  - Issues to it are ignored and never set a pending bit.
  - busy is always 0 when addressing it.
- Write: on a rising edge with wr_en=1 and wr_addr!=0:
  - reg[wr_addr] takes wr_data.
  - pending[wr_addr] is cleared.
- Issue: on a rising edge with issue_en=1 and issue_addr!=0, pending[issue_addr] is set.
- Reads: combinational, rd_data_x = reg[rd_addr_x]. Without bypass, a write is visible on the read ports from the cycle after its clock edge.
- busy_x: combinational, busy_x = pending[rd_addr_x].
- pend_cnt: registered popcount of the pending vector, updated on the same edge as the vector, so it always matches the vector contents.
- Boundary conditions:
  - Issue to an already-pending register: no change, pend_cnt unchanged.
  - Write to a non-pending register: data written, pend_cnt unchanged.
  - Issue and write to the same nonzero address on the same edge: data written and the pending bit ends set (issue wins); pend_cnt = previous + (bit was clear ? 1 : 0).
  - Issue and write to different addresses on the same edge: both take effect; pend_cnt may rise, fall or stay.
  - All 31 writable registers pending: pend_cnt=31. No overflow is possible; a further issue changes nothing.
- No X propagation: every output is defined for all input combinations after reset.

Optional Feature:
- Macro: REG_BANK_BYPASS_EN.
- Defined:
  - When wr_en=1, wr_addr!=0 and rd_addr_x==wr_addr, rd_data_x = wr_data combinationally in the same cycle.
  - busy_x is forced to 0 in that case.
  - Forwarding covers both ports independently.
- Undefined: reads return the stored value (old data) until the edge; busy_x follows the pending bit only.

Test Plan:
- Reset release -> rd_addr_a=29 gives rd_data_a=227; rd_addr_b=5 gives 0; busy_a=busy_b=0; pend_cnt=0.
- Write wr_addr=0, wr_data=0xDEADBEEF, then read addr 0 -> rd_data=0. Issue addr 0 -> pend_cnt stays 0.
- Issue addr 8 at edge N -> busy_a=1 for rd_addr_a=8 and pend_cnt=1 after N. Write addr 8 = 0x1234 at edge N+3 -> busy_a=0, pend_cnt=0 and rd_data_a=0x1234 after N+3.
- Same-edge issue and write on addr 12 (pending clear beforehand), wr_data=0x55 -> reg12=0x55, busy=1, pend_cnt=1. Same-edge issue addr 3 and write addr 8 (8 pending) -> pend_cnt net unchanged.
- Issue addrs 1..31 on consecutive edges -> pend_cnt reaches 31 and holds. Assert reset=0 mid-sequence without a clock edge -> pend_cnt=0 and all busy=0 immediately.
- With REG_BANK_BYPASS_EN: reg7=0x10, drive wr_en=1, wr_addr=7, wr_data=0x99, rd_addr_a=7 before the edge -> rd_data_a=0x99 same cycle. Without the macro -> rd_data_a=0x10 until the edge, 0x99 after.
